addr4u_chk: RTL and testbench
=============================

# addr4u_chk

Registered checking stage that sits directly downstream of the 4-bit unsigned adder. It accepts each operand pair with the adder's 5-bit sum and recomputes the golden sum. It flags and counts mismatches caused by faults in the adder, then forwards the result through a one-entry valid/ready output register. A halt state machine stops intake once a configurable error threshold is reached, so fault-injection campaigns can freeze on a failing adder.

## Interface
- ERR_CNT_W, 8, width of saturating error counter (≥ 2)
- HALT_THRESH, 16, mismatch count that forces HALT; 0 disables halting
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- clr  in  1  synchronous clear of counters and halt state
- in_valid  in  1  operand/sum triple valid
- in_ready  out  1  stage can accept a triple this cycle
- op_a  in  4  operand A[3:0] as driven to the adder
- op_b  in  4  operand B[3:0] as driven to the adder
- dut_sum  in  5  adder output O[4:0]
- out_valid  out  1  output register holds a result
- out_ready  in  1  consumer accepts result
- out_sum  out  5  forwarded sum
- out_err  out  1  mismatch flag for the held result
- out_syn  out  5  syndrome, dut_sum XOR golden
- err_cnt  out  ERR_CNT_W  saturating mismatch count
- txn_cnt  out  16  accepted-transaction count, wraps
- halted  out  1  FSM in HALT

## Operation
- Golden sum: zero-extend op_a and op_b to 5 bits and add them. The result is 0..30 and cannot overflow 5 bits.
- Mismatch: dut_sum ≠ golden.
- Accept: in_valid && in_ready.
- in_ready = !halted && !clr && (!out_valid || out_ready). This is combinational, with no input-to-ready path except out_ready.
- On accept, the output register loads:
  - out_err = mismatch
  - out_syn = dut_sum ^ golden
  - out_sum per the Configuration section
  - out_valid = 1
- Output handshake:
  - out_valid && out_ready with no accept in the same cycle: out_valid clears to 0.
  - Accept in the same cycle as a drain: the register reloads and out_valid stays 1, for full throughput.
  - out_sum, out_err and out_syn hold their values while out_valid && !out_ready.
- Counters:
  - txn_cnt increments on every accept and wraps from 0xFFFF to 0.
  - err_cnt increments on each accepted mismatch and saturates at all-ones.
- FSM states:
  - RUN → HALT on an accepted mismatch when HALT_THRESH ≠ 0 and err_cnt+1 ≥ HALT_THRESH. The saturated value counts toward the comparison.
  - HALT → RUN only on clr or reset.
  - In HALT, intake stops, but a held output still drains normally.
- clr behaviour:
  - Zeroes err_cnt and txn_cnt and forces RUN.
  - Does not touch the output register.
  - Blocks accept in its cycle.

## Timing
- Latency is 1 cycle: a triple accepted at edge k appears with out_valid=1 after edge k.
- Throughput is 1 per cycle while out_ready=1.
- halted rises in the cycle after the threshold-crossing accept, and in_ready is 0 from that cycle on.
- Reset values (rst_n=0 at an edge), all outputs:
  - out_valid=0, out_sum=0, out_err=0, out_syn=0
  - err_cnt=0, txn_cnt=0, halted=0, FSM=RUN
- Reset mid-transfer discards the held result with no drain.
- Reset has priority over clr, and clr has priority over counter increments.

## Configuration
- ADDR4U_CHK_CORRECT_EN defined: out_sum = golden, so a faulty adder result is corrected. out_err and out_syn still report the fault.
- ADDR4U_CHK_CORRECT_EN undefined: out_sum = dut_sum, passed through unmodified.
- Counters, FSM and handshake are identical in both builds.

## Test plan
- Correct sum: op_a=9, op_b=8, dut_sum=17, out_ready=1 → next cycle out_valid=1, out_sum=17, out_err=0, out_syn=0, txn_cnt=1, err_cnt=0.
- Fault, corrected build: op_a=15, op_b=15, dut_sum=14.
  - ADDR4U_CHK_CORRECT_EN defined → out_sum=30, out_err=1, out_syn=0x10, err_cnt=1.
  - Undefined → out_sum=14, with the same out_err, out_syn and err_cnt.
- Backpressure: hold out_ready=0 after one accept → in_ready=0, out_* stable for 5 cycles. Then raise out_ready with in_valid=1 → the drain and a new accept happen in the same cycle and out_valid stays 1.
- Halt, HALT_THRESH=3: send 3 mismatching triples → halted=1 on the cycle after the 3rd accept, and in_ready=0. Then pulse clr → halted=0, err_cnt=0, txn_cnt=0, in_ready=1 the next cycle.
- Saturation/wrap, ERR_CNT_W=2, HALT_THRESH=0: send 5 mismatches → err_cnt stays 3 and no halt. Preload 0xFFFF accepts → the next accept gives txn_cnt=0.
- Reset mid-operation: rst_n=0 while out_valid=1 and out_ready=0 → after the edge, all outputs read 0 and in_ready=1 once rst_n=1.

Source files
------------

// File: rtl/addr4u_chk_if.sv
// Operand/sum intake and result output handshake bundle for the addr4u_chk stage.
// master drives triples and consumes results; slave is the checking stage.
interface addr4u_chk_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic [4:0] dut_sum;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_sum;
    logic       out_err;
    logic [4:0] out_syn;

    modport master (
        output in_valid, op_a, op_b, dut_sum, out_ready,
        input  in_ready, out_valid, out_sum, out_err, out_syn
    );

    modport slave (
        input  in_valid, op_a, op_b, dut_sum, out_ready,
        output in_ready, out_valid, out_sum, out_err, out_syn
    );
endinterface

// File: rtl/addr4u_chk.sv
// Checking stage behind the 4-bit adder: recomputes the sum, counts mismatches, halts at a threshold.
// Optional feature: define ADDR4U_CHK_CORRECT_EN to forward the golden sum instead of dut_sum.
module addr4u_chk #(
    parameter int unsigned ERR_CNT_W   = 8,
    parameter int unsigned HALT_THRESH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    addr4u_chk_if.slave          bus,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [15:0]          txn_cnt,
    output logic                 halted
);

    localparam int unsigned SUM_W = 5;
    localparam int unsigned TXN_W = 16;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [SUM_W-1:0]     golden;
    logic [SUM_W-1:0]     sum_sel;
    logic                 mismatch;
    logic                 ready_c;
    logic                 accept;
    logic                 halt_hit;
    logic [ERR_CNT_W-1:0] err_inc_sat;

    logic                 out_valid_q;
    logic [SUM_W-1:0]     out_sum_q;
    logic                 out_err_q;
    logic [SUM_W-1:0]     out_syn_q;

    // Golden recompute and intake handshake
    always_comb begin
        golden      = SUM_W'(bus.op_a) + SUM_W'(bus.op_b);
        mismatch    = (bus.dut_sum != golden);
        ready_c     = (state_q == ST_RUN) && !clr && (!out_valid_q || bus.out_ready);
        accept      = bus.in_valid && ready_c;
        err_inc_sat = (&err_cnt) ? err_cnt : err_cnt + ERR_CNT_W'(1);
        halt_hit    = (HALT_THRESH != 0) && accept && mismatch
                      && (32'(err_inc_sat) >= HALT_THRESH);
`ifdef ADDR4U_CHK_CORRECT_EN
        sum_sel     = golden;
`else
        sum_sel     = bus.dut_sum;
`endif
    end

    // Halt FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Halt FSM: next state; only clr or reset leaves HALT
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN:  if (halt_hit) state_d = ST_HALT;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RUN;
        endcase
        if (clr) begin
            state_d = ST_RUN;
        end
    end

    // Transaction and saturating error counters; clr outranks increments
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            txn_cnt <= '0;
            err_cnt <= '0;
        end else if (clr) begin
            txn_cnt <= '0;
            err_cnt <= '0;
        end else if (accept) begin
            txn_cnt <= txn_cnt + TXN_W'(1);
            if (mismatch) begin
                err_cnt <= err_inc_sat;
            end
        end
    end

    // One-entry output register; reload on accept allows drain+fill in one cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_err_q   <= 1'b0;
            out_syn_q   <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_sum_q   <= sum_sel;
            out_err_q   <= mismatch;
            out_syn_q   <= bus.dut_sum ^ golden;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_err   = out_err_q;
    assign bus.out_syn   = out_syn_q;
    assign halted        = (state_q == ST_HALT);

endmodule

// File: tb/tb_addr4u_chk.sv
// Bench for addr4u_chk: default, halt-threshold-3 and 2-bit-saturating instances.
`timescale 1ns/1ps
module tb_addr4u_chk;

`ifdef ADDR4U_CHK_CORRECT_EN
    localparam bit CORR = 1'b1;
`else
    localparam bit CORR = 1'b0;
`endif

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [4:0] ds;
        logic [4:0] gold;
        logic [4:0] syn;
        logic       err;
    } vec_t;

    typedef struct {
        logic [4:0] sum;
        logic [4:0] syn;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic rst0, rst1, rst2;
    logic clr0, clr1, clr2;
    logic [7:0]  ec0, ec1;
    logic [1:0]  ec2;
    logic [15:0] tc0, tc1, tc2;
    logic        h0, h1, h2;

    int total = 0;
    int bad   = 0;
    exp_t sb[$];

    addr4u_chk_if bus0();
    addr4u_chk_if bus1();
    addr4u_chk_if bus2();

    addr4u_chk #(.ERR_CNT_W(8), .HALT_THRESH(16)) u_def (
        .clk(clk), .rst_n(rst0), .clr(clr0), .bus(bus0),
        .err_cnt(ec0), .txn_cnt(tc0), .halted(h0));
    addr4u_chk #(.ERR_CNT_W(8), .HALT_THRESH(3)) u_h3 (
        .clk(clk), .rst_n(rst1), .clr(clr1), .bus(bus1),
        .err_cnt(ec1), .txn_cnt(tc1), .halted(h1));
    addr4u_chk #(.ERR_CNT_W(2), .HALT_THRESH(0)) u_sat (
        .clk(clk), .rst_n(rst2), .clr(clr2), .bus(bus2),
        .err_cnt(ec2), .txn_cnt(tc2), .halted(h2));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: a result leaving the output register is compared with the oldest expectation
    always @(negedge clk) begin
        if (rst0 && bus0.out_valid && bus0.out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_sum", 32'(bus0.out_sum), 32'(e.sum));
                chk("sb_err", 32'(bus0.out_err), 32'(e.err));
                chk("sb_syn", 32'(bus0.out_syn), 32'(e.syn));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        int   errs;
        exp_t e;

        tbl[0] = '{a: 4'd9,  b: 4'd8,  ds: 5'd17, gold: 5'd17, syn: 5'h00, err: 1'b0};
        tbl[1] = '{a: 4'd15, b: 4'd15, ds: 5'd14, gold: 5'd30, syn: 5'h10, err: 1'b1};
        tbl[2] = '{a: 4'd0,  b: 4'd0,  ds: 5'd0,  gold: 5'd0,  syn: 5'h00, err: 1'b0};
        tbl[3] = '{a: 4'd15, b: 4'd0,  ds: 5'd15, gold: 5'd15, syn: 5'h00, err: 1'b0};
        tbl[4] = '{a: 4'd7,  b: 4'd7,  ds: 5'd15, gold: 5'd14, syn: 5'h01, err: 1'b1};
        tbl[5] = '{a: 4'd3,  b: 4'd5,  ds: 5'd0,  gold: 5'd8,  syn: 5'h08, err: 1'b1};
        tbl[6] = '{a: 4'd12, b: 4'd4,  ds: 5'd16, gold: 5'd16, syn: 5'h00, err: 1'b0};
        tbl[7] = '{a: 4'd1,  b: 4'd1,  ds: 5'd31, gold: 5'd2,  syn: 5'h1D, err: 1'b1};

        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        clr0 = 1'b0; clr1 = 1'b0; clr2 = 1'b0;
        bus0.in_valid = 1'b0; bus0.op_a = '0; bus0.op_b = '0; bus0.dut_sum = '0; bus0.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.op_a = '0; bus1.op_b = '0; bus1.dut_sum = '0; bus1.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.op_a = '0; bus2.op_b = '0; bus2.dut_sum = '0; bus2.out_ready = 1'b0;
        tick();
        tick();

        chk("rst_valid",  32'(bus0.out_valid), 32'd0);
        chk("rst_sum",    32'(bus0.out_sum),   32'd0);
        chk("rst_err",    32'(bus0.out_err),   32'd0);
        chk("rst_syn",    32'(bus0.out_syn),   32'd0);
        chk("rst_errcnt", 32'(ec0),            32'd0);
        chk("rst_txn",    32'(tc0),            32'd0);
        chk("rst_halted", 32'(h0),             32'd0);
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        tick();
        chk("rst_ready", 32'(bus0.in_ready), 32'd1);

        // Table vectors at full throughput
        errs = 0;
        bus0.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus0.in_valid = 1'b1;
            bus0.op_a     = tbl[i].a;
            bus0.op_b     = tbl[i].b;
            bus0.dut_sum  = tbl[i].ds;
            e.sum = CORR ? tbl[i].gold : tbl[i].ds;
            e.syn = tbl[i].syn;
            e.err = tbl[i].err;
            sb.push_back(e);
            tick();
            errs += int'(tbl[i].err);
            chk("vec_valid",  32'(bus0.out_valid), 32'd1);
            chk("vec_txn",    32'(tc0),            32'(i + 1));
            chk("vec_errcnt", 32'(ec0),            32'(errs));
        end
        bus0.in_valid = 1'b0;
        tick();
        tick();
        chk("vec_drained", 32'(bus0.out_valid), 32'd0);

        // Backpressure: result held stable, then drain and accept in one cycle
        bus0.out_ready = 1'b0;
        bus0.in_valid  = 1'b1;
        bus0.op_a = 4'd2; bus0.op_b = 4'd3; bus0.dut_sum = 5'd5;
        sb.push_back('{sum: 5'd5, syn: 5'd0, err: 1'b0});
        tick();
        bus0.op_a = 4'd4; bus0.op_b = 4'd4; bus0.dut_sum = 5'd8;
        for (int i = 0; i < 5; i++) begin
            chk("bp_ready", 32'(bus0.in_ready),  32'd0);
            chk("bp_valid", 32'(bus0.out_valid), 32'd1);
            chk("bp_sum",   32'(bus0.out_sum),   32'd5);
            chk("bp_err",   32'(bus0.out_err),   32'd0);
            chk("bp_syn",   32'(bus0.out_syn),   32'd0);
            tick();
        end
        bus0.out_ready = 1'b1;
        sb.push_back('{sum: 5'd8, syn: 5'd0, err: 1'b0});
        #1;
        chk("bp_ready_up", 32'(bus0.in_ready), 32'd1);
        tick();
        chk("bp_refill_valid", 32'(bus0.out_valid), 32'd1);
        chk("bp_refill_sum",   32'(bus0.out_sum),   32'd8);
        chk("bp_txn",          32'(tc0),            32'd10);
        bus0.in_valid = 1'b0;
        tick();
        tick();
        chk("bp_drained", 32'(bus0.out_valid), 32'd0);

        // Reset while a result is held under backpressure
        bus0.out_ready = 1'b0;
        bus0.in_valid  = 1'b1;
        bus0.op_a = 4'd1; bus0.op_b = 4'd2; bus0.dut_sum = 5'd7;
        tick();
        chk("mr_held", 32'(bus0.out_valid), 32'd1);
        chk("mr_syn",  32'(bus0.out_syn),   32'h04);
        bus0.in_valid = 1'b0;
        rst0 = 1'b0;
        tick();
        chk("mr_valid",  32'(bus0.out_valid), 32'd0);
        chk("mr_sum",    32'(bus0.out_sum),   32'd0);
        chk("mr_err",    32'(bus0.out_err),   32'd0);
        chk("mr_syn0",   32'(bus0.out_syn),   32'd0);
        chk("mr_errcnt", 32'(ec0),            32'd0);
        chk("mr_txn",    32'(tc0),            32'd0);
        chk("mr_halted", 32'(h0),             32'd0);
        rst0 = 1'b1;
        tick();
        chk("mr_ready", 32'(bus0.in_ready), 32'd1);

        // Halt after three mismatches, then clear
        bus1.out_ready = 1'b1;
        bus1.in_valid  = 1'b1;
        bus1.op_a = 4'd1; bus1.op_b = 4'd1; bus1.dut_sum = 5'd0;
        for (int i = 0; i < 3; i++) begin
            chk("h_pre_halted", 32'(h1), 32'd0);
            tick();
        end
        chk("h_halted", 32'(h1),             32'd1);
        chk("h_ready",  32'(bus1.in_ready),  32'd0);
        chk("h_errcnt", 32'(ec1),            32'd3);
        chk("h_txn",    32'(tc1),            32'd3);
        tick();
        chk("h_no_accept", 32'(tc1),            32'd3);
        chk("h_drain",     32'(bus1.out_valid), 32'd0);
        bus1.in_valid = 1'b0;
        clr1 = 1'b1;
        #1;
        chk("h_clr_blocks", 32'(bus1.in_ready), 32'd0);
        tick();
        clr1 = 1'b0;
        #1;
        chk("h_clr_halted", 32'(h1),            32'd0);
        chk("h_clr_errcnt", 32'(ec1),           32'd0);
        chk("h_clr_txn",    32'(tc1),           32'd0);
        chk("h_clr_ready",  32'(bus1.in_ready), 32'd1);

        // Error counter saturation and transaction counter wrap
        bus2.out_ready = 1'b1;
        bus2.in_valid  = 1'b1;
        bus2.op_a = 4'd6; bus2.op_b = 4'd6; bus2.dut_sum = 5'd13;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("s_errcnt", 32'(ec2), (i < 3) ? 32'(i + 1) : 32'd3);
            chk("s_halted", 32'(h2),  32'd0);
        end
        chk("s_txn", 32'(tc2), 32'd5);
        bus2.in_valid = 1'b0;
        clr2 = 1'b1;
        tick();
        clr2 = 1'b0;
        bus2.op_a = 4'd0; bus2.op_b = 4'd0; bus2.dut_sum = 5'd0;
        bus2.in_valid = 1'b1;
        repeat (65535) tick();
        chk("w_txn_max", 32'(tc2), 32'hFFFF);
        chk("w_errcnt",  32'(ec2), 32'd0);
        tick();
        chk("w_txn_wrap", 32'(tc2), 32'd0);
        bus2.in_valid = 1'b0;
        tick();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
